// File: rtl/fifo_ext.sv
// Single-clock synchronous FIFO with showahead/normal read modes, optional output register,
// synchronous flush and sticky overflow/underflow flags (enabled by FIFO_EXT_ERR_FLAGS_EN).
module fifo_ext #(
  parameter int unsigned DWIDTH             = 32,
  parameter int unsigned AWIDTH             = 4,
  parameter bit          SHOWAHEAD          = 1'b1,
  parameter int unsigned ALMOST_FULL_VALUE  = 12,
  parameter int unsigned ALMOST_EMPTY_VALUE = 4,
  parameter bit          REGISTER_OUTPUT    = 1'b0
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic              err_clr_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int unsigned Depth = 2 ** AWIDTH;
  localparam int unsigned CntW  = AWIDTH + 1;

  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfCnt    = CntW'(ALMOST_FULL_VALUE);
  localparam logic [CntW-1:0] AeCnt    = CntW'(ALMOST_EMPTY_VALUE);
  localparam bit              RegOut   = REGISTER_OUTPUT && !SHOWAHEAD;

  logic [DWIDTH-1:0] mem_q [Depth];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   usedw_q, usedw_d;
  logic              empty, full;
  logic              wr_en, rd_en;
  logic [DWIDTH-1:0] rd_data;

  // Flags come from the registered count, so a same-cycle read never frees space for a
  // write when full, and a same-cycle write never feeds a read when empty.
  assign empty = (usedw_q == '0);
  assign full  = (usedw_q == DepthCnt);
  assign wr_en = wrreq_i && !full && !flush_i;
  assign rd_en = rdreq_i && !empty && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
    end
  end

  // Register-array storage: a word written at edge N is readable combinationally in N+1.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

  if (!SHOWAHEAD && RegOut) begin : g_normal_reg
    logic [DWIDTH-1:0] q_q, q_r_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        q_q   <= '0;
        q_r_q <= '0;
      end else begin
        if (rd_en) begin
          q_q <= rd_data;
        end
        q_r_q <= q_q;
      end
    end

    assign q_o = q_r_q;
  end else if (!SHOWAHEAD) begin : g_normal
    logic [DWIDTH-1:0] q_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        q_q <= '0;
      end else if (rd_en) begin
        q_q <= rd_data;
      end
    end

    assign q_o = q_q;
  end else begin : g_showahead
    // Forced to zero while empty so the output is clean out of reset.
    assign q_o = empty ? '0 : rd_data;
  end

`ifdef FIFO_EXT_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // A set on the same edge as err_clr_i wins over the clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wrreq_i && full && !flush_i) begin
      ovf_d = 1'b1;
    end
    if (rdreq_i && empty && !flush_i) begin
      udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign ovf_o          = 1'b0;
  assign udf_o          = 1'b0;
`endif

  assign empty_o        = empty;
  assign full_o         = full;
  assign usedw_o        = usedw_q;
  assign almost_full_o  = (usedw_q >= AfCnt);
  assign almost_empty_o = (usedw_q < AeCnt);

endmodule

// File: doc/fifo_ext.md
# fifo_ext

Parametrised single-clock synchronous FIFO, the next generation of the team's basic FIFO. It adds the following over the basic block:
- both read modes (showahead and normal) with an optional output register in normal mode;
- a synchronous flush;
- defined precedence for simultaneous events;
- sticky overflow/underflow error flags.

It sits between any producer/consumer pair in the same clock domain and is the default buffering primitive for new datapaths.

## Interface
- DWIDTH, 32: data word width.
- AWIDTH, 4: address width; depth = 2**AWIDTH words.
- SHOWAHEAD, 1: 1 = head word presented on q_o before rdreq_i; 0 = normal mode, q_o updates after an accepted read.
- ALMOST_FULL_VALUE, 12: almost_full_o = (usedw_o >= value).
- ALMOST_EMPTY_VALUE, 4: almost_empty_o = (usedw_o < value).
- REGISTER_OUTPUT, 0: normal mode only; 1 adds one register stage to q_o. Ignored when SHOWAHEAD=1.

Ports:
- clk_i  in  1  sole clock, rising edge.
- arstn_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  synchronous flush.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request (acknowledge in showahead mode).
- err_clr_i  in  1  clears ovf_o/udf_o.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  usedw_o == 0.
- full_o  out  1  usedw_o == 2**AWIDTH.
- usedw_o  out  AWIDTH+1  stored word count, 0..2**AWIDTH.
- almost_full_o  out  1  threshold flag.
- almost_empty_o  out  1  threshold flag.
- ovf_o  out  1  sticky overflow.
- udf_o  out  1  sticky underflow.

## Operation
- **Write acceptance:** accepted iff wrreq_i && !full_o && !flush_i. Stores data_i at wr_ptr; wr_ptr increments modulo 2**AWIDTH.
- **Read acceptance:** accepted iff rdreq_i && !empty_o && !flush_i. rd_ptr increments modulo 2**AWIDTH.
- **Flags are registered state:** full_o and empty_o are decoded from registered usedw_o. A read cannot free space for a same-cycle write when full, and a write cannot feed a same-cycle read when empty.
- **Count arithmetic:** usedw_o +1 on write-only, -1 on read-only, unchanged on both or neither. Width AWIDTH+1, never wraps.
- **Full + wrreq_i + rdreq_i:** read accepted, write dropped; usedw_o goes 16 → 15 (AWIDTH=4).
- **Empty + wrreq_i + rdreq_i:** write accepted, read dropped; usedw_o goes 0 → 1.
- **Flush:** flush_i has priority over everything.
  - Next edge: pointers = 0, usedw_o = 0.
  - Memory contents are untouched; q_o is held.
  - Requests during flush are neither accepted nor counted as errors.
- **Showahead mode:** q_o = mem[rd_ptr] whenever empty_o=0. q_o is don't-care while empty_o=1.
- **Normal mode:** q_o loads mem[rd_ptr] on an accepted read, otherwise holds.
- **Almost flags:** combinational compares on registered usedw_o.
- **Reset values:**
  - usedw_o=0, empty_o=1, full_o=0, almost_full_o=0, q_o=0, ovf_o=0, udf_o=0.
  - almost_empty_o=1 (for ALMOST_EMPTY_VALUE>0).

## Timing
- Write accepted at edge N:
  - usedw_o and flags update after edge N.
  - Showahead: the word is visible on q_o with empty_o=0 in cycle N+1. The memory read path must cover this (bypass or register-array memory).
- Normal mode, read accepted at edge N:
  - REGISTER_OUTPUT=0: q_o valid in cycle N+1.
  - REGISTER_OUTPUT=1: q_o valid in cycle N+2.
- Back-to-back reads and writes sustain one word per cycle per side.
- **Pointer wrap-around:** 15 → 0 with AWIDTH=4; no bubble.
- **Reset assertion:** async reset mid-operation forces the reset values immediately, independent of clk_i. Reset deassertion is synchronised externally.

## Configuration
- Macro: FIFO_EXT_ERR_FLAGS_EN.
- **Defined:**
  - ovf_o sets on wrreq_i && full_o && !flush_i.
  - udf_o sets on rdreq_i && empty_o && !flush_i.
  - Both flags are sticky until err_clr_i; a set on the same edge wins over the clear.
  - Flush does not clear them.
- **Undefined:** ovf_o and udf_o are tied to 0 and err_clr_i is ignored. Ports remain so the interface is identical in both builds.

## Test plan
- **Fill/drain (AWIDTH=4, SHOWAHEAD=1):**
  - Stimulus: write 0x00..0x0F, then read 16.
  - Response: full_o=1 at usedw_o=16; almost_full_o rises when usedw_o reaches 12. Reads return 0x00..0x0F in order; empty_o=1 after the 16th read.
- **Normal mode, REGISTER_OUTPUT=1:**
  - Stimulus: write 0xA5, then rdreq_i at edge N.
  - Response: q_o=0xA5 in cycle N+2 and stays 0 before that.
- **Simultaneous requests at the boundaries:**
  - Full + wrreq_i=rdreq_i=1: usedw_o → 15, the written word is discarded, ovf_o=1 (macro on).
  - Empty + both: usedw_o → 1, udf_o=1.
- **Wrap-around:**
  - Stimulus: 40 interleaved write/read pairs with random occupancy 1..15.
  - Response: output sequence matches the scoreboard; usedw_o is never out of range.
- **Flush:**
  - Stimulus: at usedw_o=9, assert flush_i together with wrreq_i.
  - Response: next cycle usedw_o=0, empty_o=1, no ovf_o/udf_o. A subsequent write of 0x33 reads back as 0x33.
- **Async reset:**
  - Stimulus: drop arstn_i between edges at usedw_o=5.
  - Response: all outputs take their reset values before the next edge; with the macro on, ovf_o and udf_o clear.
